// File: rtl/id_hazard_controller.sv
// IF/ID pipeline register and decode-to-execute issue control for the 5-stage MIPS pipeline:
// load-use bubbles, jump/branch squashing, memory-wait freeze and saturating stall/flush counters.
module id_hazard_controller #(
   parameter int          CNT_W    = 16,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_valid,
   input  logic [31:0]      if_instr,
   input  logic [31:0]      if_pc,
   output logic             if_ready,
   input  logic             ex_is_lw,
   input  logic [4:0]       ex_rt,
   input  logic             ex_branch_taken,
   input  logic             ex_ready,
   output logic             issue_valid,
   output logic [31:0]      issue_instr,
   output logic [31:0]      issue_pc,
   output logic             jump_taken,
   output logic [31:0]      jump_target,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [1:0]       dbg_state
);

   // Handshake: IF offers {if_valid, if_instr, if_pc}; it is taken on a rising edge where
   // if_valid & if_ready. EX captures issue_* on a rising edge where issue_valid is 1.

   localparam logic [5:0] OP_R   = 6'h00;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2B;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_J   = 6'h02;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_LDSTALL = 2'd1,
      ST_MEMWAIT = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_id_valid;
   logic [31:0]      r_id_instr;
   logic [31:0]      r_id_pc;
   logic [31:0]      r_last_instr;
   logic [31:0]      r_last_pc;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic [5:0]       w_op;
   logic [4:0]       w_rs;
   logic [4:0]       w_rt;
   logic             w_reads_rs;
   logic             w_reads_rt;
   logic             w_hazard;
   logic             w_issue;
   logic             w_if_ready;
   logic             w_jump;
   logic             w_id_load;
   logic             w_id_kill;
   logic             w_stall_inc;
   logic [1:0]       w_flush_inc;
   logic [3:0]       w_pc4_hi;
   logic [CNT_W:0]   w_stall_sum;
   logic [CNT_W:0]   w_flush_sum;

   assign w_op       = r_id_instr[31:26];
   assign w_rs       = r_id_instr[25:21];
   assign w_rt       = r_id_instr[20:16];
   assign w_reads_rt = (w_op == OP_R) || (w_op == OP_SW) || (w_op == OP_BEQ);
   assign w_reads_rs = (w_op != OP_J);
   assign w_hazard   = r_id_valid && ex_is_lw && (ex_rt != 5'd0) &&
                       ((w_reads_rs && (ex_rt == w_rs)) || (w_reads_rt && (ex_rt == w_rt)));

   // LDSTALL skips the hazard check: the producing lw has left EX by then. MEMWAIT does
   // re-check, since the lw in EX was frozen along with the consumer in ID.
   always_comb begin
      w_state_nxt = ST_RUN;
      w_issue     = 1'b0;
      w_if_ready  = 1'b1;
      w_jump      = 1'b0;
      w_id_load   = 1'b0;
      w_id_kill   = 1'b0;
      w_stall_inc = 1'b0;
      w_flush_inc = 2'd0;
      if (ex_branch_taken) begin
         w_id_kill   = 1'b1;
         w_flush_inc = {1'b0, r_id_valid} + {1'b0, if_valid};
      end else if (!ex_ready) begin
         w_if_ready  = 1'b0;
         w_state_nxt = ST_MEMWAIT;
         w_stall_inc = 1'b1;
      end else if ((r_state != ST_LDSTALL) && w_hazard) begin
         w_if_ready  = 1'b0;
         w_state_nxt = ST_LDSTALL;
         w_stall_inc = 1'b1;
      end else begin
         w_issue = r_id_valid;
         w_jump  = r_id_valid && (w_op == OP_J);
         if (w_jump) begin
            w_id_kill   = 1'b1;
            w_flush_inc = {1'b0, if_valid};
         end else begin
            w_id_load = 1'b1;
         end
      end
   end

   // Counters clamp at all-ones using a one-bit-wider sum.
   assign w_stall_sum = {1'b0, r_stall_cnt} + {{CNT_W{1'b0}}, w_stall_inc};
   assign w_flush_sum = {1'b0, r_flush_cnt} + {{(CNT_W-1){1'b0}}, w_flush_inc};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_RUN;
         r_id_valid   <= 1'b0;
         r_id_instr   <= 32'd0;
         r_id_pc      <= RESET_PC;
         r_last_instr <= 32'd0;
         r_last_pc    <= RESET_PC;
         r_stall_cnt  <= '0;
         r_flush_cnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_id_kill) begin
            r_id_valid <= 1'b0;
         end else if (w_id_load) begin
            r_id_valid <= if_valid;
            r_id_instr <= if_instr;
            r_id_pc    <= if_pc;
         end
         if (w_issue) begin
            r_last_instr <= r_id_instr;
            r_last_pc    <= r_id_pc;
         end
         r_stall_cnt <= w_stall_sum[CNT_W] ? {CNT_W{1'b1}} : w_stall_sum[CNT_W-1:0];
         r_flush_cnt <= w_flush_sum[CNT_W] ? {CNT_W{1'b1}} : w_flush_sum[CNT_W-1:0];
      end
   end

   // Bits [31:28] of id_pc+4: a carry reaches bit 28 only when pc[27:2] is all ones.
   assign w_pc4_hi    = r_id_pc[31:28] + {3'b000, &r_id_pc[27:2]};

   assign if_ready    = w_if_ready;
   assign issue_valid = w_issue;
   assign issue_instr = w_issue ? r_id_instr : r_last_instr;
   assign issue_pc    = w_issue ? r_id_pc : r_last_pc;
   assign jump_taken  = w_jump;
   assign jump_target = {w_pc4_hi, r_id_instr[25:0], 2'b00};
   assign stall_cnt   = r_stall_cnt;
   assign flush_cnt   = r_flush_cnt;
   assign dbg_state   = r_state;

endmodule
